// File: rtl/pixel_frame_streamer.sv
// Ping-pong frame buffer that stores written images and streams them out in raster order
// over valid/ready with SOF/EOL/EOF markers and optional inter-line idle gaps.
module pixel_frame_streamer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IMG_W    = 28,
    parameter int unsigned IMG_H    = 28,
    parameter int unsigned LINE_GAP = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_sof_o,
    output logic              out_eol_o,
    output logic              out_eof_o,
    output logic [CNT_W-1:0]  frame_cnt_o
);

    localparam int unsigned PIX = IMG_W * IMG_H;
    localparam int unsigned AW  = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int unsigned CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned GW  = 4;

    localparam logic [AW-1:0] AddrLast = AW'(PIX - 1);
    localparam logic [CW-1:0] ColLast  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast  = RW'(IMG_H - 1);
    localparam logic [GW-1:0] GapLast  = GW'(LINE_GAP - 1);

    typedef enum logic [1:0] {StIdle, StStream, StGap} state_e;

    logic [DATA_W-1:0] mem_q [2][PIX];

    logic [1:0]        full_q, full_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic              wr_ready_q, wr_ready_d;
    state_e            state_q, state_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic              eof_q, eof_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              wr_accept;
    logic              load;
    logic              ld_bank;
    logic [AW-1:0]     ld_addr;
    logic [CW-1:0]     ld_col;
    logic [RW-1:0]     ld_row;

    assign wr_accept = wr_en_i && wr_ready_q && !clear_i;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_sel_q][wr_addr_q] <= wr_data_i;
        end
    end

    always_comb begin
        full_d     = full_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        wr_addr_d  = wr_addr_q;
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        gap_d      = gap_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        eof_d      = eof_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        ld_bank    = rd_sel_q;
        ld_addr    = rd_addr_q;
        ld_col     = col_q;
        ld_row     = row_q;

        if (wr_accept) begin
            if (wr_addr_q == AddrLast) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
                wr_addr_d        = '0;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (full_q[rd_sel_q]) begin
                    load    = 1'b1;
                    ld_addr = '0;
                    ld_col  = '0;
                    ld_row  = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (valid_q && out_ready_i) begin
                    if (eof_q) begin
                        full_d[rd_sel_q] = 1'b0;
                        rd_sel_d         = ~rd_sel_q;
                        cnt_d            = cnt_q + 1'b1;
                        // The other bank may already hold a frame: chain it without a bubble.
                        if (full_q[~rd_sel_q]) begin
                            load    = 1'b1;
                            ld_bank = ~rd_sel_q;
                            ld_addr = '0;
                            ld_col  = '0;
                            ld_row  = '0;
                        end else begin
                            valid_d = 1'b0;
                            sof_d   = 1'b0;
                            eol_d   = 1'b0;
                            eof_d   = 1'b0;
                            state_d = StIdle;
                        end
                    end else if (eol_q) begin
                        ld_addr = rd_addr_q + 1'b1;
                        ld_row  = row_q + 1'b1;
                        ld_col  = '0;
                        if (LINE_GAP > 0) begin
                            rd_addr_d = ld_addr;
                            row_d     = ld_row;
                            col_d     = '0;
                            gap_d     = '0;
                            valid_d   = 1'b0;
                            sof_d     = 1'b0;
                            eol_d     = 1'b0;
                            eof_d     = 1'b0;
                            state_d   = StGap;
                        end else begin
                            load = 1'b1;
                        end
                    end else begin
                        ld_addr = rd_addr_q + 1'b1;
                        ld_col  = col_q + 1'b1;
                        load    = 1'b1;
                    end
                end
            end
            StGap: begin
                // Address and row were already advanced when the gap was entered.
                if (gap_q == GapLast) begin
                    load    = 1'b1;
                    state_d = StStream;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            data_d    = mem_q[ld_bank][ld_addr];
            valid_d   = 1'b1;
            sof_d     = (ld_row == '0) && (ld_col == '0);
            eol_d     = (ld_col == ColLast);
            eof_d     = (ld_col == ColLast) && (ld_row == RowLast);
            rd_addr_d = ld_addr;
            row_d     = ld_row;
            col_d     = ld_col;
        end

        wr_ready_d = !full_d[wr_sel_d];

        if (clear_i) begin
            full_d     = '0;
            wr_sel_d   = 1'b0;
            rd_sel_d   = 1'b0;
            wr_addr_d  = '0;
            wr_ready_d = 1'b1;
            state_d    = StIdle;
            rd_addr_d  = '0;
            col_d      = '0;
            row_d      = '0;
            gap_d      = '0;
            data_d     = '0;
            valid_d    = 1'b0;
            sof_d      = 1'b0;
            eol_d      = 1'b0;
            eof_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_ready_q <= 1'b1;
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_ready_q <= wr_ready_d;
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wr_ready_o  = wr_ready_q;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign out_sof_o   = sof_q;
    assign out_eol_o   = eol_q;
    assign out_eof_o   = eof_q;
    assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Bench for pixel_frame_streamer: a 4x3 instance without line gaps and one with LINE_GAP=2,
// checked against a frame-level reference stream built from the written pixels.
module tb_pixel_frame_streamer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int PIX  = W * H;
    localparam int LGAP = 2;

    typedef logic [7:0] frame_t [PIX];
    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
        int         cyc;
    } beat_t;
    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, clear;
    logic        wr_en, wr_ready, out_valid, out_ready, out_sof, out_eol, out_eof;
    logic [7:0]  wr_data, out_data;
    logic [15:0] frame_cnt;
    logic        wr_en2, wr_ready2, out_valid2, out_ready2, out_sof2, out_eol2, out_eof2;
    logic [7:0]  wr_data2, out_data2;
    logic [15:0] frame_cnt2;

    int    n_pass = 0;
    int    n_total = 0;
    int    cyc = 0;
    int    exp_cnt = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    logic  prev_stall = 1'b0;
    logic [10:0] prev_beat = '0;

    pixel_frame_streamer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .LINE_GAP(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready), .out_data_o(out_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_sof_o(out_sof), .out_eol_o(out_eol), .out_eof_o(out_eof),
        .frame_cnt_o(frame_cnt)
    );

    pixel_frame_streamer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .LINE_GAP(LGAP), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .wr_en_i(wr_en2), .wr_data_i(wr_data2),
        .wr_ready_o(wr_ready2), .out_data_o(out_data2), .out_valid_o(out_valid2),
        .out_ready_i(out_ready2), .out_sof_o(out_sof2), .out_eol_o(out_eol2),
        .out_eof_o(out_eof2), .frame_cnt_o(frame_cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    // Handshake recorder and stall-stability monitor for the gap-free instance.
    always @(negedge clk) begin
        if (rst_n && prev_stall) begin
            chk("stall_valid_held", 32'(out_valid), 1);
            chk("stall_beat_held", 32'({out_data, out_sof, out_eol, out_eof}), 32'(prev_beat));
        end
        if (rst_n && !clear && out_valid && out_ready)
            got_q.push_back('{data: out_data, sof: out_sof, eol: out_eol, eof: out_eof, cyc: cyc});
        prev_stall <= rst_n && !clear && out_valid && !out_ready;
        prev_beat  <= {out_data, out_sof, out_eol, out_eof};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t seq_frame(input int base);
        frame_t f;
        for (int i = 0; i < PIX; i++) f[i] = 8'(base + i);
        return f;
    endfunction

    // Reference: a frame is its pixels in order, markers purely from position in the frame.
    task automatic push_frame(input frame_t f);
        for (int i = 0; i < PIX; i++)
            exp_q.push_back('{data: f[i], sof: (i == 0), eol: (i % W == W - 1),
                              eof: (i == PIX - 1), cyc: 0});
    endtask

    task automatic write_frame(input frame_t f);
        for (int i = 0; i < PIX; i++) begin
            int g;
            g = 0;
            wr_en   = 1'b1;
            wr_data = f[i];
            while (!wr_ready && g < 500) begin
                step();
                g++;
            end
            if (g >= 500) chk("write_timeout", 32'(wr_ready), 1);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            step();
            k++;
        end
        chk("wait_valid", 32'(out_valid), 1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("beat_count", 32'(got_q.size()), 32'(n));
    endtask

    task automatic cmp_stream(input string name);
        int n;
        chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk(name, 32'({got_q[i].data, got_q[i].sof, got_q[i].eol, got_q[i].eof}),
                32'({exp_q[i].data, exp_q[i].sof, exp_q[i].eol, exp_q[i].eof}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [PIX];
        frame_t     fa, fb, fd, fe, ff, fg;
        frame_t     rf [3];
        logic [8:0] gap_exp[$];
        logic [3:0] pat;

        tbl = '{'{8'h01, 1, 0, 0}, '{8'h02, 0, 0, 0}, '{8'h03, 0, 0, 0}, '{8'h04, 0, 1, 0},
                '{8'h05, 0, 0, 0}, '{8'h06, 0, 0, 0}, '{8'h07, 0, 0, 0}, '{8'h08, 0, 1, 0},
                '{8'h09, 0, 0, 0}, '{8'h0A, 0, 0, 0}, '{8'h0B, 0, 0, 0}, '{8'h0C, 0, 1, 1}};
        pat = 4'b1001;

        rst_n = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
        wr_en2 = 1'b0; wr_data2 = '0; out_ready2 = 1'b0;
        #2 rst_n = 1'b0;
        #6;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_markers", 32'({out_sof, out_eol, out_eof}), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_valid_gap_dut", 32'(out_valid2), 0);
        #4 rst_n = 1'b1;
        step();

        // Single frame, table-driven, cycle-exact.
        out_ready = 1'b1;
        for (int i = 0; i < PIX; i++) begin
            chk("t1_wr_ready", 32'(wr_ready), 1);
            wr_en = 1'b1;
            wr_data = tbl[i].pix;
            step();
        end
        wr_en = 1'b0;
        chk("t1_latency_not_yet", 32'(out_valid), 0);
        step();
        for (int i = 0; i < PIX; i++) begin
            chk("t1_valid", 32'(out_valid), 1);
            chk("t1_beat", 32'({out_data, out_sof, out_eol, out_eof}),
                32'({tbl[i].pix, tbl[i].sof, tbl[i].eol, tbl[i].eof}));
            step();
        end
        chk("t1_valid_after", 32'(out_valid), 0);
        exp_cnt = 1;
        chk("t1_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Backpressure with ready pattern 1,0,0,1.
        out_ready = 1'b0;
        got_q.delete();
        exp_q.delete();
        push_frame(seq_frame(1));
        write_frame(seq_frame(1));
        for (int k = 0; k < 300 && got_q.size() < PIX; k++) begin
            out_ready = pat[k % 4];
            step();
        end
        out_ready = 1'b0;
        cmp_stream("t2_bp");
        exp_cnt++;
        chk("t2_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // LINE_GAP instance: expected valid/data pattern from row arithmetic.
        out_ready2 = 1'b1;
        for (int i = 0; i < PIX; i++) begin
            gap_exp.push_back({1'b1, 8'(i + 1)});
            if (i % W == W - 1 && i != PIX - 1)
                for (int g = 0; g < LGAP; g++) gap_exp.push_back(9'h000);
        end
        for (int g = 0; g < 3; g++) gap_exp.push_back(9'h000);
        for (int i = 0; i < PIX; i++) begin
            wr_en2 = 1'b1;
            wr_data2 = 8'(i + 1);
            step();
        end
        wr_en2 = 1'b0;
        step();
        foreach (gap_exp[k]) begin
            chk("t3_gap_valid", 32'(out_valid2), 32'(gap_exp[k][8]));
            if (gap_exp[k][8]) chk("t3_gap_data", 32'(out_data2), 32'(gap_exp[k][7:0]));
            step();
        end
        chk("t3_frame_cnt", 32'(frame_cnt2), 1);

        // Ping-pong: both banks full, writes ignored, back-to-back streaming.
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b0;
        fa = seq_frame(8'h10);
        fb = seq_frame(8'h20);
        push_frame(fa);
        push_frame(fb);
        write_frame(fa);
        write_frame(fb);
        chk("t4_wr_ready_both_full", 32'(wr_ready), 0);
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1;
            wr_data = 8'hEE;
            step();
            chk("t4_wr_ready_held_low", 32'(wr_ready), 0);
        end
        wr_en = 1'b0;
        out_ready = 1'b1;
        wait_beats(2 * PIX, 200);
        cmp_stream("t4_pingpong");
        if (got_q.size() > PIX)
            chk("t4_no_bubble", 32'(got_q[PIX].cyc - got_q[PIX - 1].cyc), 1);
        exp_cnt += 2;
        chk("t4_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("t4_wr_ready_after", 32'(wr_ready), 1);
        out_ready = 1'b0;

        // Randomized pixels, write stalls and backpressure against the frame-level model.
        got_q.delete();
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < PIX; i++) rf[f][i] = 8'($urandom);
            push_frame(rf[f]);
        end
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int i = 0; i < PIX; i++) begin
                        int   g;
                        logic acc;
                        g = 0;
                        acc = 1'b0;
                        while (!acc && g < 2000) begin
                            wr_en = ($urandom_range(0, 3) != 0);
                            wr_data = wr_en ? rf[f][i] : 8'($urandom);
                            acc = wr_en && wr_ready;
                            step();
                            g++;
                        end
                        if (!acc) chk("t5_write_timeout", 32'(acc), 1);
                    end
                end
                wr_en = 1'b0;
            end
            begin
                for (int k = 0; k < 3000 && got_q.size() < 3 * PIX; k++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                end
                out_ready = 1'b0;
            end
        join
        cmp_stream("t5_random");
        exp_cnt += 3;
        chk("t5_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // clear after 5 beats, with a partial frame being written into the other bank.
        got_q.delete();
        exp_q.delete();
        fd = seq_frame(8'h40);
        fe = seq_frame(8'h50);
        write_frame(fd);
        wait_valid(20);
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b1;
            wr_en = 1'b1;
            wr_data = 8'h99;
            step();
        end
        out_ready = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        wr_en = 1'b0;
        chk("t6_clear_valid", 32'(out_valid), 0);
        chk("t6_clear_wr_ready", 32'(wr_ready), 1);
        chk("t6_clear_markers", 32'({out_sof, out_eol, out_eof}), 0);
        chk("t6_clear_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("t6_partial_beats", 32'(got_q.size()), 5);
        push_frame(fd);
        repeat (PIX - 5) void'(exp_q.pop_back());
        push_frame(fe);
        out_ready = 1'b1;
        write_frame(fe);
        wait_beats(5 + PIX, 200);
        cmp_stream("t6_after_clear");
        exp_cnt++;
        chk("t6_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Asynchronous reset between clock edges mid-frame.
        ff = seq_frame(8'h60);
        fg = seq_frame(8'h70);
        write_frame(ff);
        wait_valid(20);
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t7_arst_valid", 32'(out_valid), 0);
        chk("t7_arst_data", 32'(out_data), 0);
        chk("t7_arst_markers", 32'({out_sof, out_eol, out_eof}), 0);
        chk("t7_arst_frame_cnt", 32'(frame_cnt), 0);
        chk("t7_arst_wr_ready", 32'(wr_ready), 1);
        #2 rst_n = 1'b1;
        step();
        got_q.delete();
        exp_q.delete();
        push_frame(fg);
        write_frame(fg);
        wait_beats(PIX, 200);
        cmp_stream("t7_after_reset");
        chk("t7_frame_cnt", 32'(frame_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
